// File: rtl/sd_sector_streamer.sv
// rtl/sd_sector_streamer.sv - byte log FIFO streamed to an SD SPI master, one 512-byte sector per block write
module sd_sector_streamer #(
    parameter int          FIFO_DEPTH     = 1024,
    parameter logic [31:0] START_SECTOR   = 32'd0,
    parameter logic [7:0]  PAD_BYTE       = 8'h00,
    parameter logic [5:0]  REG_TRANS_TYPE = 6'h02,
    parameter logic [5:0]  REG_TRANS_CTRL = 6'h03,
    parameter logic [5:0]  REG_TRANS_STS  = 6'h04,
    parameter logic [5:0]  REG_TRANS_ERR  = 6'h05,
    parameter logic [5:0]  REG_SD_ADDR0   = 6'h07,
    parameter logic [5:0]  REG_TX_FIFO    = 6'h10
) (
    input  logic        clk_peri,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [5:0]  sd_addr,
    output logic [7:0]  sd_wdata,
    input  logic [7:0]  sd_rdata,
    output logic        sd_strobe,
    output logic        sd_we,
    input  logic        sd_ack,
    output logic        busy,
    output logic        error,
    output logic [31:0] sector_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] SECTOR_BYTES = CW'(512);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_RESET, S_INIT_TYPE, S_INIT_GO, S_INIT_POLL, S_INIT_CHK, S_IDLE, S_FILL,
        S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3, S_WR_TYPE, S_WR_GO, S_WR_POLL, S_WR_CHK, S_FAIL
    } state_t;

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            flush_pending, flush_pending_next;
    logic [8:0]      fill_cnt;
    logic            fill_pop;
    logic [31:0]     sector_addr;

    logic            empty, full, push, pop, done;
    logic            bus_req, req_we, clr_flush, sector_ok, flush_set;
    logic [5:0]      req_addr;
    logic [7:0]      req_wdata;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign push  = in_valid && in_ready && !full;
    assign done  = sd_strobe && sd_ack;
    assign pop   = done && (state == S_FILL) && fill_pop;
    assign busy  = (state != S_IDLE) && (state != S_FAIL);
    assign flush_set = flush && !(empty && (state == S_IDLE));

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        clr_flush  = 1'b0;
        sector_ok  = 1'b0;
        case (state)
            S_RESET: state_next = S_INIT_TYPE;
            S_INIT_TYPE, S_WR_TYPE: begin
                bus_req   = 1'b1;
                req_we    = 1'b1;
                req_addr  = REG_TRANS_TYPE;
                req_wdata = (state == S_INIT_TYPE) ? 8'd1 : 8'd3;
                if (done) state_next = (state == S_INIT_TYPE) ? S_INIT_GO : S_WR_GO;
            end
            S_INIT_GO, S_WR_GO: begin
                bus_req   = 1'b1;
                req_we    = 1'b1;
                req_addr  = REG_TRANS_CTRL;
                req_wdata = 8'd1;
                if (done) state_next = (state == S_INIT_GO) ? S_INIT_POLL : S_WR_POLL;
            end
            S_INIT_POLL, S_WR_POLL: begin
                bus_req  = 1'b1;
                req_addr = REG_TRANS_STS;
                if (done && !sd_rdata[0]) state_next = (state == S_INIT_POLL) ? S_INIT_CHK : S_WR_CHK;
            end
            S_INIT_CHK, S_WR_CHK: begin
                bus_req  = 1'b1;
                req_addr = REG_TRANS_ERR;
                if (done) begin
                    if (sd_rdata != 8'd0) begin
                        state_next = S_FAIL;
                    end else begin
                        state_next = S_IDLE;
                        sector_ok  = (state == S_WR_CHK);
                    end
                end
            end
            S_IDLE: begin
                if (count >= SECTOR_BYTES || (flush_pending && !empty)) begin
                    state_next = S_FILL;
                end else if (flush_pending) begin
                    clr_flush = 1'b1;
                end
            end
            S_FILL: begin
                // Padding only happens on flush sectors; full sectors never see an empty FIFO.
                bus_req   = 1'b1;
                req_we    = 1'b1;
                req_addr  = REG_TX_FIFO;
                req_wdata = empty ? PAD_BYTE : mem[rd_ptr];
                if (done && fill_cnt == 9'd511) begin
                    state_next = S_ADDR0;
                    clr_flush  = (count_next == '0);
                end
            end
            S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3: begin
                bus_req = 1'b1;
                req_we  = 1'b1;
                case (state)
                    S_ADDR0: begin req_addr = REG_SD_ADDR0;         req_wdata = sector_addr[7:0];   end
                    S_ADDR1: begin req_addr = REG_SD_ADDR0 + 6'd1;  req_wdata = sector_addr[15:8];  end
                    S_ADDR2: begin req_addr = REG_SD_ADDR0 + 6'd2;  req_wdata = sector_addr[23:16]; end
                    default: begin req_addr = REG_SD_ADDR0 + 6'd3;  req_wdata = sector_addr[31:24]; end
                endcase
                if (done) begin
                    case (state)
                        S_ADDR0: state_next = S_ADDR1;
                        S_ADDR1: state_next = S_ADDR2;
                        S_ADDR2: state_next = S_ADDR3;
                        default: state_next = S_WR_TYPE;
                    endcase
                end
            end
            default: state_next = S_FAIL;
        endcase
    end

    // A flush arriving in the same cycle as a clear must survive to the next IDLE.
    assign flush_pending_next = flush_set ? 1'b1 : (clr_flush ? 1'b0 : flush_pending);

    always_ff @(posedge clk_peri) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk_peri) begin
        if (!reset) begin
            state         <= S_RESET;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
            in_ready      <= 1'b0;
            sd_strobe     <= 1'b0;
            sd_we         <= 1'b0;
            sd_addr       <= '0;
            sd_wdata      <= '0;
            fill_cnt      <= '0;
            fill_pop      <= 1'b0;
            sector_addr   <= START_SECTOR;
            sector_count  <= '0;
            error         <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            flush_pending <= flush_pending_next;
            in_ready      <= (count_next != FULL_COUNT) && !flush_pending_next && (state_next != S_RESET);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (bus_req && !sd_strobe) begin
                sd_strobe <= 1'b1;
                sd_we     <= req_we;
                sd_addr   <= req_addr;
                sd_wdata  <= req_wdata;
                fill_pop  <= (state == S_FILL) && !empty;
            end else if (done) begin
                sd_strobe <= 1'b0;
            end
            if (state == S_IDLE) begin
                fill_cnt <= '0;
            end else if (state == S_FILL && done) begin
                fill_cnt <= fill_cnt + 9'd1;
            end
            if (sector_ok) begin
                sector_addr  <= sector_addr + 32'd1;
                sector_count <= sector_count + 32'd1;
            end
            if (state_next == S_FAIL) error <= 1'b1;
        end
    end
endmodule

// File: doc/sd_sector_streamer.md
# sd_sector_streamer

Streams a continuous byte log onto an SD card one 512-byte sector at a time. It sits directly upstream of the SD-card SPI master peripheral and drives that peripheral's byte-wide register bus as a bus master. Data producers push bytes through a valid/ready port into a local FIFO. The block initialises the card, moves each full sector into the SPI master's TX FIFO, starts a block write at an auto-incrementing sector address, and polls for completion.

## Interface
- `FIFO_DEPTH`, 1024: local byte FIFO depth; power of two, ≥ 512.
- `START_SECTOR`, 32'd0: first sector address written after reset.
- `PAD_BYTE`, 8'h00: filler byte for flushed partial sectors.
- `REG_TRANS_TYPE`, 6'h02: SPI master transaction-type register.
- `REG_TRANS_CTRL`, 6'h03: SPI master transaction-start register.
- `REG_TRANS_STS`, 6'h04: SPI master status register; bit0 = busy.
- `REG_TRANS_ERR`, 6'h05: SPI master error register.
- `REG_SD_ADDR0`, 6'h07: SD address byte 0 register; bytes 1..3 are at +1..+3.
- `REG_TX_FIFO`, 6'h10: SPI master TX FIFO data register.
- `clk_peri`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-low reset (0 = reset).
- `in_data`, in, 8: log byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: byte accepted when `in_valid & in_ready`.
- `flush`, in, 1: one-cycle pulse requesting that the current partial sector be padded and written.
- `sd_addr`, out, 6: register address to the SPI master.
- `sd_wdata`, out, 8: write data to the SPI master.
- `sd_rdata`, in, 8: read data from the SPI master.
- `sd_strobe`, out, 1: bus request.
- `sd_we`, out, 1: 1 = write, 0 = read.
- `sd_ack`, in, 1: transaction complete.
- `busy`, out, 1: any state other than IDLE or FAIL.
- `error`, out, 1: sticky; set on entry to FAIL.
- `sector_count`, out, 32: number of sectors successfully written since reset.

## Operation
- Reset values:
  - `in_ready` = 0, `sd_strobe` = 0, `sd_we` = 0, `sd_addr` = 0, `sd_wdata` = 0.
  - `busy` = 1, `error` = 0, `sector_count` = 0.
  - FIFO empty; sector address = `START_SECTOR`; flush pending cleared.
- FIFO:
  - `in_ready` = !full && !flush_pending && state != RESET.
  - The write side runs concurrently with every state, including FAIL.
  - Count width is log2(`FIFO_DEPTH`)+1. Pointers wrap modulo `FIFO_DEPTH`.
  - A push and a pop in the same cycle leave the count unchanged.
- FSM states:
  - RESET: unconditional transition to INIT_TYPE.
  - INIT_TYPE: write `REG_TRANS_TYPE` = 1.
  - INIT_GO: write `REG_TRANS_CTRL` = 1.
  - INIT_POLL: read `REG_TRANS_STS`. Repeat while bit0 = 1.
  - INIT_CHK: read `REG_TRANS_ERR`. Nonzero → FAIL; zero → IDLE.
  - IDLE: go to FILL if count ≥ 512, or if flush_pending and count > 0. If flush_pending and count = 0, clear flush_pending and stay in IDLE.
  - FILL: perform 512 writes to `REG_TX_FIFO`.
    - While the FIFO is non-empty, each write pops one byte.
    - If the FIFO is empty and the sector is flush-driven, the write uses `PAD_BYTE`.
    - Non-flush fills always find data, because count ≥ 512 at entry.
  - ADDR0..ADDR3: write sector address bytes LSB first to `REG_SD_ADDR0`+0..+3.
  - WR_TYPE: write `REG_TRANS_TYPE` = 3.
  - WR_GO: write `REG_TRANS_CTRL` = 1.
  - WR_POLL: same as INIT_POLL.
  - WR_CHK: read `REG_TRANS_ERR`.
    - Zero: sector address +1 (wraps at 2^32), `sector_count` +1, go to IDLE.
    - Nonzero: go to FAIL.
  - FAIL: terminal until reset. No bus activity. The FIFO still accepts bytes until full.
- Flush:
  - A `flush` pulse sets flush_pending, unless count = 0 and state is IDLE.
  - If count ≥ 512, full sectors are written first. The padded sector follows and consumes the remainder.
  - flush_pending clears on exit from a FILL in which the FIFO emptied.
  - A `flush` pulse arriving during FILL is latched and handled in the next IDLE.

## Timing
- Bus rules:
  - One transaction at a time.
  - `sd_addr`, `sd_wdata`, `sd_we` and `sd_strobe` are registered and held stable until the cycle in which `sd_ack` = 1.
  - `sd_strobe` falls in the cycle after the ack.
  - There is at least one idle cycle between transactions.
  - `sd_rdata` is sampled in the ack cycle.
  - `sd_ack` while `sd_strobe` = 0 is ignored.
- FIFO pop occurs in the ack cycle of the corresponding FILL write. The byte is loaded into `sd_wdata` when the strobe is issued, so the FIFO has a first-word-fall-through output.
- `in_ready` changes one cycle after the count reaches full or drops below it.
- Reset asserted mid-operation (e.g. mid-FILL or mid-poll):
  - Strobe drops in the next cycle.
  - The FIFO contents are discarded.
  - Initialisation repeats after release.
- With zero-wait ack (ack in the first strobe cycle), each transaction takes 2 cycles. Minimum sector overhead beyond polling is (512+7)·2 cycles.

## Test plan
- Reset release, bus model acks with 1-cycle latency, STS returns busy for 3 reads, ERR = 0 → writes (02←1), (03←1), 3+1 STS reads, 1 ERR read, then `busy` = 0.
- Push 512 bytes 0x00..0xFF,0x00..0xFF → 512 TX_FIFO writes in order. Address bytes written are 00,00,00,00 (with `START_SECTOR` = 0). Then (02←3), (03←1). After completion, `sector_count` = 1 and the next sector is written to address 1.
- Push 700 bytes continuously while the model delays ack by 5 cycles → `in_ready` never drops below capacity rules. Exactly one sector is written. 188 bytes remain in the FIFO.
- Push 10 bytes, pulse `flush` → 10 data writes, then 502 writes of `PAD_BYTE`. `in_ready` = 0 until FILL completes. A `flush` with an empty FIFO produces no bus activity.
- ERR read returns 8'h10 after a write → FAIL, `error` = 1, `busy` = 0, `sector_count` unchanged, no further strobes.
- `reset` = 0 during FILL at byte 200 → strobe = 0 next cycle, `in_ready` = 0. After release, the full init sequence repeats and `sector_count` = 0.
